data_mem_responder: RTL and testbench

Responder end of the CPU data-memory port. It serves loads and stores from the single-cycle core. Each access goes either to a word-organised RAM with byte lanes or to a small MMIO register bank holding a GPIO output register, a free-running cycle counter and a sticky error register. Loads are combinational so the core needs no stall. Stores commit on the rising clock edge.

---
 rtl/data_mem_responder_pkg.sv | 28 ++
 rtl/data_mem_responder_if.sv | 14 +
 rtl/data_mem_responder_load_extend.sv | 30 +++
 rtl/data_mem_responder.sv | 149 ++++++++++++++
 tb/tb_data_mem_responder.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/data_mem_responder_pkg.sv
// Shared encodings for the data-memory responder: store sizes, load sizes,
// MMIO register word offsets and ERR bit positions.
package data_mem_responder_pkg;

    typedef enum logic [1:0] {
        MW_NONE = 2'b00,
        MW_SB   = 2'b01,
        MW_SH   = 2'b10,
        MW_SW   = 2'b11
    } memWrite_e;

    typedef enum logic [2:0] {
        LD_LB  = 3'b000,
        LD_LH  = 3'b001,
        LD_LW  = 3'b010,
        LD_LBU = 3'b100,
        LD_LHU = 3'b101
    } sizeLoad_e;

    // MMIO registers are selected by addr[3:2] inside the 16-byte window
    localparam logic [1:0] MMIO_IDX_GPIO  = 2'd0;
    localparam logic [1:0] MMIO_IDX_CYCLE = 2'd1;
    localparam logic [1:0] MMIO_IDX_ERR   = 2'd2;

    localparam int ERR_MISALIGN = 0;
    localparam int ERR_RANGE    = 1;

endpackage

// File: rtl/data_mem_responder_if.sv
// Core-to-responder data-memory bus: the core is the master, the responder the slave.
interface data_mem_responder_if;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  mem_write;
    logic [2:0]  size_load;
    logic        mem_read;
    logic [31:0] rdata;

    modport master (output addr, output wdata, output mem_write,
                    output size_load, output mem_read, input rdata);
    modport slave  (input addr, input wdata, input mem_write,
                    input size_load, input mem_read, output rdata);
endinterface

// File: rtl/data_mem_responder_load_extend.sv
// Picks the addressed byte/half out of a 32-bit word and sign- or zero-extends it.
module load_extend
    import data_mem_responder_pkg::*;
(
    input  logic [31:0] i_word,
    input  logic [1:0]  i_byteSel,
    input  logic [2:0]  i_sizeLoad,
    output logic [31:0] o_rdata
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_byte = 8'(i_word >> {i_byteSel, 3'b000});
    assign w_half = i_byteSel[1] ? i_word[31:16] : i_word[15:0];

    // Extension by load size; unused funct3 codes read back as zero
    always_comb begin
        o_rdata = '0;
        case (i_sizeLoad)
            LD_LB:   o_rdata = {{24{w_byte[7]}}, w_byte};
            LD_LH:   o_rdata = {{16{w_half[15]}}, w_half};
            LD_LW:   o_rdata = i_word;
            LD_LBU:  o_rdata = {24'd0, w_byte};
            LD_LHU:  o_rdata = {16'd0, w_half};
            default: o_rdata = '0;
        endcase
    end

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder: byte-lane RAM plus GPIO/CYCLE/ERR MMIO bank.
// Loads are combinational, stores and register updates happen at the clock edge.
module data_mem_responder
    import data_mem_responder_pkg::*;
#(
    parameter int          DEPTH_WORDS = 1024,
    parameter logic [31:0] MMIO_BASE   = 32'hFFFF_0000
)
(
    input  logic                 clk,
    input  logic                 reset,
    data_mem_responder_if.slave  bus,
    output logic [31:0]          gpio_out,
    output logic                 err_irq
);

    localparam int          AW        = $clog2(DEPTH_WORDS);
    localparam logic [31:0] RAM_BYTES = 32'(4 * DEPTH_WORDS);

    logic [31:0] r_mem [DEPTH_WORDS];
    logic [31:0] r_gpio;
    logic [31:0] r_cycle;
    logic [1:0]  r_err;

    logic          w_ramHit, w_mmioHit, w_inRange;
    logic          w_storeActive, w_storeAligned, w_storeOk;
    logic          w_loadValid, w_loadActive, w_loadAligned, w_loadOk;
    logic [3:0]    w_byteEn;
    logic [31:0]   w_storeData;
    logic [31:0]   w_readWord, w_extData;
    logic [1:0]    w_newErr, w_errClear;
    logic          w_ramWe, w_mmioWe;
    logic [AW-1:0] w_wordIdx;

    assign w_ramHit  = bus.addr < RAM_BYTES;
    assign w_mmioHit = (bus.addr[31:4] == MMIO_BASE[31:4]) && (bus.addr[3:2] != 2'b11);
    assign w_inRange = w_ramHit || w_mmioHit;
    assign w_wordIdx = bus.addr[AW+1:2];

    // Store lane enables, replicated store data and alignment check
    always_comb begin
        w_storeAligned = 1'b1;
        w_byteEn       = 4'b0000;
        w_storeData    = bus.wdata;
        case (bus.mem_write)
            MW_SB: begin
                w_byteEn    = 4'b0001 << bus.addr[1:0];
                w_storeData = {4{bus.wdata[7:0]}};
            end
            MW_SH: begin
                w_storeAligned = !bus.addr[0];
                w_byteEn       = bus.addr[1] ? 4'b1100 : 4'b0011;
                w_storeData    = {2{bus.wdata[15:0]}};
            end
            MW_SW: begin
                w_storeAligned = (bus.addr[1:0] == 2'b00);
                w_byteEn       = 4'b1111;
            end
            default: w_byteEn = 4'b0000;
        endcase
        if (w_mmioHit && bus.mem_write != MW_SW) begin
            w_storeAligned = 1'b0;
        end
    end

    // Load size legality and alignment check
    always_comb begin
        w_loadValid   = 1'b1;
        w_loadAligned = 1'b1;
        case (bus.size_load)
            LD_LB, LD_LBU: w_loadAligned = 1'b1;
            LD_LH, LD_LHU: w_loadAligned = !bus.addr[0];
            LD_LW:         w_loadAligned = (bus.addr[1:0] == 2'b00);
            default:       w_loadValid   = 1'b0;
        endcase
        if (w_mmioHit && bus.size_load != LD_LW) begin
            w_loadAligned = 1'b0;
        end
    end

    assign w_storeActive = (bus.mem_write != MW_NONE);
    assign w_loadActive  = bus.mem_read && w_loadValid;
    assign w_storeOk     = w_storeActive && w_inRange && w_storeAligned;
    assign w_loadOk      = w_loadActive && w_inRange && w_loadAligned;
    assign w_ramWe       = w_storeOk && w_ramHit;
    assign w_mmioWe      = w_storeOk && w_mmioHit;

    assign w_newErr[ERR_MISALIGN] = w_inRange &&
        ((w_storeActive && !w_storeAligned) || (w_loadActive && !w_loadAligned));
    assign w_newErr[ERR_RANGE]    = (w_storeActive || w_loadActive) && !w_inRange;
    assign w_errClear = (w_mmioWe && bus.addr[3:2] == MMIO_IDX_ERR) ? bus.wdata[1:0] : 2'b00;

    // Read word source: RAM or the addressed MMIO register
    always_comb begin
        w_readWord = '0;
        if (w_ramHit) begin
            w_readWord = r_mem[w_wordIdx];
        end else if (w_mmioHit) begin
            case (bus.addr[3:2])
                MMIO_IDX_GPIO:  w_readWord = r_gpio;
                MMIO_IDX_CYCLE: w_readWord = r_cycle;
                MMIO_IDX_ERR:   w_readWord = {30'd0, r_err};
                default:        w_readWord = '0;
            endcase
        end
    end

    load_extend u_loadExtend (
        .i_word     (w_readWord),
        .i_byteSel  (bus.addr[1:0]),
        .i_sizeLoad (bus.size_load),
        .o_rdata    (w_extData)
    );

    assign bus.rdata = w_loadOk ? w_extData : '0;
    assign gpio_out  = r_gpio;
    assign err_irq   = |r_err;

    // RAM byte-lane write; held off while reset is low so a pending store is dropped
    always_ff @(posedge clk) begin
        if (reset && w_ramWe) begin
            for (int i = 0; i < 4; i++) begin
                if (w_byteEn[i]) begin
                    r_mem[w_wordIdx][8*i +: 8] <= w_storeData[8*i +: 8];
                end
            end
        end
    end

    // MMIO registers: GPIO write, free-running CYCLE with load, sticky ERR with W1C
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_gpio  <= '0;
            r_cycle <= '0;
            r_err   <= '0;
        end else begin
            if (w_mmioWe && bus.addr[3:2] == MMIO_IDX_CYCLE) begin
                r_cycle <= bus.wdata;
            end else begin
                r_cycle <= r_cycle + 32'd1;
            end
            if (w_mmioWe && bus.addr[3:2] == MMIO_IDX_GPIO) begin
                r_gpio <= bus.wdata;
            end
            r_err <= (r_err & ~w_errClear) | w_newErr;
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed testbench for data_mem_responder: RAM loads/stores, errors, CYCLE, GPIO, reset.
module tb_data_mem_responder;
    import data_mem_responder_pkg::*;

    localparam logic [31:0] MMIO = 32'hFFFF_0000;

    logic        clk;
    logic        reset;
    logic [31:0] gpio_out;
    logic        err_irq;
    logic [31:0] got;
    int          checks;
    int          errors;

    data_mem_responder_if bus();

    data_mem_responder #(.DEPTH_WORDS(1024), .MMIO_BASE(MMIO)) dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus.slave),
        .gpio_out (gpio_out),
        .err_irq  (err_irq)
    );

    // Free-running 10-unit clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] d,
                                 input logic [1:0] mw, input logic rd, input logic [2:0] sz);
        bus.addr      = a;
        bus.wdata     = d;
        bus.mem_write = mw;
        bus.mem_read  = rd;
        bus.size_load = sz;
    endtask

    task automatic idleBus();
        applyStimulus(32'h0, 32'h0, MW_NONE, 1'b0, LD_LW);
    endtask

    task automatic storeOp(input logic [31:0] a, input logic [31:0] d, input logic [1:0] mw);
        applyStimulus(a, d, mw, 1'b0, LD_LW);
        @(posedge clk);
        #1;
        idleBus();
    endtask

    task automatic loadOp(input logic [31:0] a, input logic [2:0] sz, output logic [31:0] data);
        applyStimulus(a, 32'h0, MW_NONE, 1'b1, sz);
        #1;
        data = bus.rdata;
        idleBus();
    endtask

    task automatic test_reset();
        reset = 1'b0;
        idleBus();
        #3;
        checks++;
        if (gpio_out !== 32'h0) begin errors++; $display("[TB] FAIL reset_gpio: got %h expected %h", gpio_out, 32'h0); end
        checks++;
        if (err_irq !== 1'b0) begin errors++; $display("[TB] FAIL reset_irq: got %b expected %b", err_irq, 1'b0); end
        loadOp(MMIO + 32'd4, LD_LW, got);
        checks++;
        if (got !== 32'h0) begin errors++; $display("[TB] FAIL reset_cycle: got %h expected %h", got, 32'h0); end
        @(negedge clk);
        reset = 1'b1;
        storeOp(32'h10, 32'h0, MW_SW);
        storeOp(32'h14, 32'h0, MW_SW);
    endtask

    task automatic test_word_and_extend();
        storeOp(32'h10, 32'h8040_C0FF, MW_SW);
        loadOp(32'h10, LD_LW, got);
        checks++;
        if (got !== 32'h8040_C0FF) begin errors++; $display("[TB] FAIL lw_10: got %h expected %h", got, 32'h8040_C0FF); end
        loadOp(32'h10, LD_LB, got);
        checks++;
        if (got !== 32'hFFFF_FFFF) begin errors++; $display("[TB] FAIL lb_10: got %h expected %h", got, 32'hFFFF_FFFF); end
        loadOp(32'h10, LD_LBU, got);
        checks++;
        if (got !== 32'h0000_00FF) begin errors++; $display("[TB] FAIL lbu_10: got %h expected %h", got, 32'h0000_00FF); end
        loadOp(32'h12, LD_LH, got);
        checks++;
        if (got !== 32'hFFFF_8040) begin errors++; $display("[TB] FAIL lh_12: got %h expected %h", got, 32'hFFFF_8040); end
        loadOp(32'h12, LD_LHU, got);
        checks++;
        if (got !== 32'h0000_8040) begin errors++; $display("[TB] FAIL lhu_12: got %h expected %h", got, 32'h0000_8040); end
        loadOp(32'h10, 3'b011, got);
        checks++;
        if (got !== 32'h0) begin errors++; $display("[TB] FAIL invalid_size: got %h expected %h", got, 32'h0); end
        applyStimulus(32'h10, 32'h0, MW_NONE, 1'b0, LD_LW);
        #1;
        checks++;
        if (bus.rdata !== 32'h0) begin errors++; $display("[TB] FAIL no_read: got %h expected %h", bus.rdata, 32'h0); end
        idleBus();
    endtask

    task automatic test_byte_store();
        storeOp(32'h13, 32'h0000_00AB, MW_SB);
        loadOp(32'h10, LD_LW, got);
        checks++;
        if (got !== 32'hAB40_C0FF) begin errors++; $display("[TB] FAIL sb_lw: got %h expected %h", got, 32'hAB40_C0FF); end
        loadOp(32'h13, LD_LBU, got);
        checks++;
        if (got !== 32'h0000_00AB) begin errors++; $display("[TB] FAIL sb_lbu13: got %h expected %h", got, 32'h0000_00AB); end
        loadOp(32'h11, LD_LB, got);
        checks++;
        if (got !== 32'hFFFF_FFC0) begin errors++; $display("[TB] FAIL lb_11: got %h expected %h", got, 32'hFFFF_FFC0); end
    endtask

    task automatic test_misaligned();
        storeOp(32'h11, 32'h0000_1234, MW_SH);
        checks++;
        if (err_irq !== 1'b1) begin errors++; $display("[TB] FAIL mis_irq: got %b expected %b", err_irq, 1'b1); end
        loadOp(32'h10, LD_LW, got);
        checks++;
        if (got !== 32'hAB40_C0FF) begin errors++; $display("[TB] FAIL mis_ram: got %h expected %h", got, 32'hAB40_C0FF); end
        loadOp(MMIO + 32'd8, LD_LW, got);
        checks++;
        if (got !== 32'h1) begin errors++; $display("[TB] FAIL mis_err: got %h expected %h", got, 32'h1); end
        loadOp(32'h14, LD_LW, got);
        checks++;
        if (got !== 32'h0) begin errors++; $display("[TB] FAIL lw_14: got %h expected %h", got, 32'h0); end
        storeOp(MMIO + 32'd8, 32'h1, MW_SW);
        checks++;
        if (err_irq !== 1'b0) begin errors++; $display("[TB] FAIL clr_irq: got %b expected %b", err_irq, 1'b0); end
        loadOp(MMIO + 32'd8, LD_LW, got);
        checks++;
        if (got !== 32'h0) begin errors++; $display("[TB] FAIL clr_err: got %h expected %h", got, 32'h0); end
    endtask

    task automatic test_read_before_write();
        applyStimulus(32'h14, 32'h1122_3344, MW_SW, 1'b1, LD_LW);
        #1;
        checks++;
        if (bus.rdata !== 32'h0) begin errors++; $display("[TB] FAIL rbw_old: got %h expected %h", bus.rdata, 32'h0); end
        @(posedge clk);
        #1;
        idleBus();
        loadOp(32'h14, LD_LW, got);
        checks++;
        if (got !== 32'h1122_3344) begin errors++; $display("[TB] FAIL rbw_new: got %h expected %h", got, 32'h1122_3344); end
    endtask

    task automatic test_cycle();
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        loadOp(MMIO + 32'd4, LD_LW, got);
        checks++;
        if (got !== 32'd10) begin errors++; $display("[TB] FAIL cycle_10: got %h expected %h", got, 32'd10); end
        storeOp(MMIO + 32'd4, 32'hFFFF_FFFE, MW_SW);
        loadOp(MMIO + 32'd4, LD_LW, got);
        checks++;
        if (got !== 32'hFFFF_FFFE) begin errors++; $display("[TB] FAIL cycle_load: got %h expected %h", got, 32'hFFFF_FFFE); end
        repeat (2) @(posedge clk);
        #1;
        loadOp(MMIO + 32'd4, LD_LW, got);
        checks++;
        if (got !== 32'h0) begin errors++; $display("[TB] FAIL cycle_wrap: got %h expected %h", got, 32'h0); end
    endtask

    task automatic test_gpio_reset();
        storeOp(MMIO, 32'h0000_005A, MW_SW);
        checks++;
        if (gpio_out !== 32'h0000_005A) begin errors++; $display("[TB] FAIL gpio_wr: got %h expected %h", gpio_out, 32'h0000_005A); end
        applyStimulus(MMIO, 32'h0000_0077, MW_SW, 1'b0, LD_LW);
        #3;
        reset = 1'b0;
        #1;
        checks++;
        if (gpio_out !== 32'h0) begin errors++; $display("[TB] FAIL gpio_async: got %h expected %h", gpio_out, 32'h0); end
        @(posedge clk);
        #1;
        checks++;
        if (gpio_out !== 32'h0) begin errors++; $display("[TB] FAIL gpio_held: got %h expected %h", gpio_out, 32'h0); end
        idleBus();
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (gpio_out !== 32'h0) begin errors++; $display("[TB] FAIL gpio_after: got %h expected %h", gpio_out, 32'h0); end
    endtask

    task automatic test_error_priority();
        storeOp(32'h1010, 32'hDEAD_BEEF, MW_SW);
        loadOp(32'h10, LD_LW, got);
        checks++;
        if (got !== 32'hAB40_C0FF) begin errors++; $display("[TB] FAIL oor_store: got %h expected %h", got, 32'hAB40_C0FF); end
        applyStimulus(32'h1000, 32'h0, MW_NONE, 1'b1, LD_LW);
        #1;
        checks++;
        if (bus.rdata !== 32'h0) begin errors++; $display("[TB] FAIL oor_load: got %h expected %h", bus.rdata, 32'h0); end
        @(posedge clk);
        #1;
        idleBus();
        loadOp(MMIO + 32'd8, LD_LW, got);
        checks++;
        if (got !== 32'h2) begin errors++; $display("[TB] FAIL oor_err: got %h expected %h", got, 32'h2); end
        applyStimulus(32'h11, 32'h0, MW_NONE, 1'b1, LD_LH);
        @(posedge clk);
        #1;
        idleBus();
        loadOp(MMIO + 32'd8, LD_LW, got);
        checks++;
        if (got !== 32'h3) begin errors++; $display("[TB] FAIL both_err: got %h expected %h", got, 32'h3); end
        applyStimulus(MMIO + 32'd8, 32'h1, MW_SW, 1'b1, LD_LH);
        @(posedge clk);
        #1;
        idleBus();
        loadOp(MMIO + 32'd8, LD_LW, got);
        checks++;
        if (got !== 32'h3) begin errors++; $display("[TB] FAIL set_wins: got %h expected %h", got, 32'h3); end
        storeOp(MMIO + 32'd8, 32'h3, MW_SW);
        loadOp(MMIO + 32'd8, LD_LW, got);
        checks++;
        if (got !== 32'h0) begin errors++; $display("[TB] FAIL clr_all: got %h expected %h", got, 32'h0); end
        checks++;
        if (err_irq !== 1'b0) begin errors++; $display("[TB] FAIL clr_all_irq: got %b expected %b", err_irq, 1'b0); end
    endtask

    // Scenario sequence followed by the summary line
    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_word_and_extend();
        test_byte_store();
        test_misaligned();
        test_read_before_write();
        test_cycle();
        test_gpio_reset();
        test_error_priority();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
